// File: rtl/traffic_light_ctrl_if.sv
// Lamp/command bundle between the intersection controller and its environment.
// The master side drives the tick, pedestrian button and maintenance request.
// The slave side (the controller) drives the lamp outputs and debug phase.
interface traffic_light_ctrl_if;
  logic       tick_1hz;
  logic       ped_req;
  logic       flash;
  logic       ns_g;
  logic       ns_y;
  logic       ns_r;
  logic       ew_g;
  logic       ew_y;
  logic       ew_r;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    output tick_1hz, ped_req, flash,
    input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending, phase
  );

  modport slave (
    input  tick_1hz, ped_req, flash,
    output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending, phase
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with programmable phase lengths, all-red
// clearance after each yellow, a latched pedestrian walk phase and a
// maintenance flashing-yellow mode. All timing advances on tick_1hz only.
module traffic_light_ctrl #(
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int CLEAR_TICKS  = 1,
  parameter int WALK_TICKS   = 3,
  parameter int CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  traffic_light_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    NS_G   = 3'd0,
    NS_Y   = 3'd1,
    RED_NS = 3'd2,
    EW_G   = 3'd3,
    EW_Y   = 3'd4,
    RED_EW = 3'd5,
    WALK   = 3'd6,
    FLASH  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_TICKS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ped_pending, ped_pending_nxt;
  logic             flash_on, flash_on_nxt;
  // 1: walk resumes at EW_G, 0: walk resumes at NS_G
  logic             resume_ew, resume_ew_nxt;

  // Terminal dwell count for the phase currently held in the state register.
  function automatic logic [CNT_W-1:0] last_count(input state_t s);
    case (s)
      NS_G, EW_G:     last_count = GREEN_LAST;
      NS_Y, EW_Y:     last_count = YELLOW_LAST;
      RED_NS, RED_EW: last_count = CLEAR_LAST;
      WALK:           last_count = WALK_LAST;
      default:        last_count = '0;
    endcase
  endfunction

  // State, dwell counter, pedestrian latch, flash phase and resume target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= NS_G;
      cnt         <= '0;
      ped_pending <= 1'b0;
      flash_on    <= 1'b0;
      resume_ew   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ped_pending <= ped_pending_nxt;
      flash_on    <= flash_on_nxt;
      resume_ew   <= resume_ew_nxt;
    end
  end

  // Next-state logic: flash entry/exit outranks tick-driven advance.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    ped_pending_nxt = ped_pending | bus.ped_req;
    flash_on_nxt    = flash_on;
    resume_ew_nxt   = resume_ew;

    if (state != FLASH && bus.flash) begin
      // A coincident tick is dropped: the counter restarts rather than advancing.
      state_nxt    = FLASH;
      cnt_nxt      = '0;
      flash_on_nxt = 1'b1;
    end else if (state == FLASH) begin
      if (!bus.flash) begin
        // Leave through an all-red clearance so service restarts at NS_G.
        state_nxt = RED_EW;
        cnt_nxt   = '0;
      end else if (bus.tick_1hz) begin
        flash_on_nxt = ~flash_on;
      end
    end else if (bus.tick_1hz) begin
      if (cnt == last_count(state)) begin
        cnt_nxt = '0;
        case (state)
          NS_G: state_nxt = NS_Y;
          NS_Y: state_nxt = RED_NS;
          RED_NS: begin
            // Decision uses the registered latch, so a request arriving on
            // this very tick waits for the next red exit.
            if (ped_pending) begin
              state_nxt       = WALK;
              resume_ew_nxt   = 1'b1;
              ped_pending_nxt = 1'b0;
            end else begin
              state_nxt = EW_G;
            end
          end
          EW_G: state_nxt = EW_Y;
          EW_Y: state_nxt = RED_EW;
          RED_EW: begin
            if (ped_pending) begin
              state_nxt       = WALK;
              resume_ew_nxt   = 1'b0;
              ped_pending_nxt = 1'b0;
            end else begin
              state_nxt = NS_G;
            end
          end
          WALK:    state_nxt = resume_ew ? EW_G : NS_G;
          default: state_nxt = NS_G;
        endcase
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Moore lamp decode straight from the state register.
  always_comb begin
    bus.ns_g        = 1'b0;
    bus.ns_y        = 1'b0;
    bus.ns_r        = 1'b0;
    bus.ew_g        = 1'b0;
    bus.ew_y        = 1'b0;
    bus.ew_r        = 1'b0;
    bus.walk        = 1'b0;
    bus.ped_pending = ped_pending;
    bus.phase       = state;
    case (state)
      NS_G: begin
        bus.ns_g = 1'b1;
        bus.ew_r = 1'b1;
      end
      NS_Y: begin
        bus.ns_y = 1'b1;
        bus.ew_r = 1'b1;
      end
      EW_G: begin
        bus.ew_g = 1'b1;
        bus.ns_r = 1'b1;
      end
      EW_Y: begin
        bus.ew_y = 1'b1;
        bus.ns_r = 1'b1;
      end
      RED_NS, RED_EW: begin
        bus.ns_r = 1'b1;
        bus.ew_r = 1'b1;
      end
      WALK: begin
        bus.ns_r = 1'b1;
        bus.ew_r = 1'b1;
        bus.walk = 1'b1;
      end
      default: begin
        bus.ns_y = flash_on;
        bus.ew_y = flash_on;
      end
    endcase
  end

endmodule
